uart_rx_fifo: RTL and testbench

Parametrised successor to the basic UART receiver. Adds:
- configurable data width, parity and stop bits;
- a 2-flop input synchronizer;
- 3-point majority-vote sampling;
- false-start rejection and per-character parity/framing error flags;
- a receive FIFO with sticky overrun.

It sits between the board serial pin and the MMIO UART register block, and presents a ready/valid byte stream to the core.

---
 rtl/uart_rx_fifo_pkg.sv | 30 +++
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo_sync_fifo.sv | 74 +++++++
 rtl/uart_rx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the
// symbol/sample timing derivation used by both receive and transmit paths.
package uart_rx_fifo_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StPar,
      StStop,
      StWaitHigh
   } rx_state_e;

   // Clock cycles per serial symbol after oscillator trim.
   function automatic int unsigned symbol_time(input int unsigned clock_freq,
                                               input int unsigned baud_rate,
                                               input int unsigned clk_offset);
      return clock_freq / baud_rate - clk_offset;
   endfunction

   // Counter value at the nominal centre of a symbol.
   function automatic int unsigned sample_time(input int unsigned sym_time);
      return sym_time / 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive byte stream between the UART receiver and its consumer.
//   data_out_ready : consumer accepts head entry
//   data_out_valid : head entry present
//   data_out       : head data, LSB = first bit on the line
//   parity_error   : head entry parity mismatch
//   frame_error    : head entry had a low stop bit
interface uart_rx_fifo_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 data_out_ready;
   logic                 data_out_valid;
   logic [DATA_BITS-1:0] data_out;
   logic                 parity_error;
   logic                 frame_error;

   modport master (
      input  data_out_ready,
      output data_out_valid,
      output data_out,
      output parity_error,
      output frame_error
   );

   modport slave (
      output data_out_ready,
      input  data_out_valid,
      input  data_out,
      input  parity_error,
      input  frame_error
   );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with a registered head entry.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wr_data (ignored when full unless popping too)
//   pop      : drop head entry (ignored when empty)
//   rd_data  : registered head entry
//   full, empty, count : occupancy
module uart_rx_fifo_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // The next head is the entry being written when it lands on the new read slot.
   always_comb begin
      rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      if (do_push && (rd_ptr_d == wr_ptr_q)) begin
         head_d = wr_data;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rd_data = head_q;
   assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, parity/framing checks and a
// receive FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   serial_in     : asynchronous RX pin, idle high
//   rx_if         : ready/valid stream of received characters plus flags
//   overrun_clear : clears the sticky overrun flag
//   overrun       : a character was dropped on a full FIFO
//   fifo_count    : entries held
//   rx_busy       : receiver is inside a frame
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 125_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned CLK_OFFSET = 0,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            serial_in,
   uart_rx_fifo_if.master                  rx_if,
   input  logic                            overrun_clear,
   output logic                            overrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            rx_busy
);
   localparam int unsigned SYMBOL_TIME = symbol_time(CLOCK_FREQ, BAUD_RATE, CLK_OFFSET);
   localparam int unsigned SAMPLE_TIME = sample_time(SYMBOL_TIME);
   localparam int unsigned CNT_W       = $clog2(SYMBOL_TIME);
   localparam int unsigned BIT_W       = $clog2(DATA_BITS);
   localparam int unsigned ENTRY_W     = DATA_BITS + 2;

   localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_TIME - 1);
   localparam logic [CNT_W-1:0] SAMP_0   = CNT_W'(SAMPLE_TIME - 1);
   localparam logic [CNT_W-1:0] SAMP_1   = CNT_W'(SAMPLE_TIME);
   localparam logic [CNT_W-1:0] SAMP_2   = CNT_W'(SAMPLE_TIME + 1);
   localparam logic [CNT_W-1:0] VOTE_AT  = CNT_W'(SAMPLE_TIME + 2);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);
   localparam bit               PAR_EN     = (PARITY != PARITY_NONE);
   localparam logic             PAR_TARGET = (PARITY == PARITY_ODD);

   logic [1:0]           sync_q;
   logic                 rxd;
   rx_state_e            state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2:0]           samp_q;
   logic [BIT_W-1:0]     bit_idx_q;
   logic                 stop_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_err_q, frm_err_q, push_q;
   logic                 vote, maj, frm_err_d;

   logic                 fifo_full, fifo_empty, pop, drop;
   logic [ENTRY_W-1:0]   head;
   logic                 overrun_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], serial_in};
      end
   end
   assign rxd = sync_q[1];

   assign vote      = (cnt_q == VOTE_AT);
   assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
   assign frm_err_d = frm_err_q | ~maj;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         samp_q     <= 3'b111;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         push_q     <= 1'b0;
      end else begin
         push_q <= 1'b0;
         // Held at zero while idle so the first START cycle sees count 0.
         if (state_q == StIdle || state_q == StWaitHigh || cnt_q == SYM_LAST) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (cnt_q == SAMP_0) samp_q[0] <= rxd;
         if (cnt_q == SAMP_1) samp_q[1] <= rxd;
         if (cnt_q == SAMP_2) samp_q[2] <= rxd;

         case (state_q)
            StIdle: begin
               if (!rxd) begin
                  state_q   <= StStart;
                  par_err_q <= 1'b0;
                  frm_err_q <= 1'b0;
               end
            end
            StStart: begin
               if (vote) begin
                  if (maj) begin
                     state_q <= StIdle;
                  end else begin
                     state_q   <= StData;
                     bit_idx_q <= '0;
                  end
               end
            end
            StData: begin
               if (vote) begin
                  shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                  if (bit_idx_q == LAST_BIT) begin
                     state_q    <= PAR_EN ? StPar : StStop;
                     stop_idx_q <= 1'b0;
                  end else begin
                     bit_idx_q <= bit_idx_q + BIT_W'(1);
                  end
               end
            end
            StPar: begin
               if (vote) begin
                  par_err_q <= ((^shift_q) ^ maj) != PAR_TARGET;
                  state_q   <= StStop;
               end
            end
            StStop: begin
               if (vote) begin
                  frm_err_q <= frm_err_d;
                  // Finish at mid-stop so a back-to-back start bit is caught on time.
                  if (stop_idx_q == LAST_STOP) begin
                     push_q  <= 1'b1;
                     state_q <= frm_err_d ? StWaitHigh : StIdle;
                  end else begin
                     stop_idx_q <= 1'b1;
                  end
               end
            end
            StWaitHigh: begin
               if (rxd) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign pop  = rx_if.data_out_ready;
   assign drop = push_q & fifo_full & ~pop;

   uart_rx_fifo_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_q),
      .wr_data ({par_err_q, frm_err_q, shift_q}),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (drop) begin
         overrun_q <= 1'b1;
      end else if (overrun_clear) begin
         overrun_q <= 1'b0;
      end
   end

   assign overrun              = overrun_q;
   assign rx_busy              = (state_q != StIdle);
   assign rx_if.data_out_valid = ~fifo_empty;
   assign rx_if.data_out       = head[DATA_BITS-1:0];
   assign rx_if.frame_error    = head[DATA_BITS];
   assign rx_if.parity_error   = head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an 8N1 receiver (a) and a 7E2 receiver (b), both at
// 20 clocks per symbol, with popped entries collected into queues.
module tb_uart_rx_fifo;
   import uart_rx_fifo_pkg::*;

   localparam int unsigned CLK_F = 2_000_000;
   localparam int unsigned BAUD  = 100_000;
   localparam int unsigned BIT   = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ser_a = 1'b1, ser_b = 1'b1;
   logic       clr_a = 1'b0, clr_b = 1'b0;
   logic       ovr_a, ovr_b, busy_a, busy_b;
   logic [2:0] cnt_a;
   logic [1:0] cnt_b;

   uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
   uart_rx_fifo_if #(.DATA_BITS(7)) if_b ();

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .CLOCK_FREQ (CLK_F),
      .BAUD_RATE  (BAUD),
      .CLK_OFFSET (0),
      .DATA_BITS  (8),
      .PARITY     (PARITY_NONE),
      .STOP_BITS  (1),
      .FIFO_DEPTH (4)
   ) dut_a (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (ser_a),
      .rx_if         (if_a),
      .overrun_clear (clr_a),
      .overrun       (ovr_a),
      .fifo_count    (cnt_a),
      .rx_busy       (busy_a)
   );

   uart_rx_fifo #(
      .CLOCK_FREQ (CLK_F),
      .BAUD_RATE  (BAUD),
      .CLK_OFFSET (0),
      .DATA_BITS  (7),
      .PARITY     (PARITY_EVEN),
      .STOP_BITS  (2),
      .FIFO_DEPTH (2)
   ) dut_b (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (ser_b),
      .rx_if         (if_b),
      .overrun_clear (clr_b),
      .overrun       (ovr_b),
      .fifo_count    (cnt_b),
      .rx_busy       (busy_b)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [9:0] q_a [$];
   logic [8:0] q_b [$];
   int         vcyc_a = 0;
   int         ovr_cyc_a = 0;

   // Record every accepted entry as {parity_error, frame_error, data}.
   always @(negedge clk) begin
      if (!rst && if_a.data_out_valid && if_a.data_out_ready)
         q_a.push_back({if_a.parity_error, if_a.frame_error, if_a.data_out});
      if (!rst && if_b.data_out_valid && if_b.data_out_ready)
         q_b.push_back({if_b.parity_error, if_b.frame_error, if_b.data_out});
      if (if_a.data_out_valid) vcyc_a++;
      if (ovr_a) ovr_cyc_a++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive n line bits LSB first, one symbol each, then return the line to idle.
   task automatic send(input int sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel == 0) ser_a = bits[i];
         else          ser_b = bits[i];
         step(BIT);
      end
      if (sel == 0) ser_a = 1'b1;
      else          ser_b = 1'b1;
   endtask

   function automatic logic [15:0] frame8(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   task automatic expect_a(input string tag, input logic [9:0] exp);
      logic [9:0] got;
      if (q_a.size() > 0) got = q_a.pop_front();
      else                got = ~exp;
      check_eq(tag, 32'(got), 32'(exp));
   endtask

   task automatic expect_b(input string tag, input logic [8:0] exp);
      logic [8:0] got;
      if (q_b.size() > 0) got = q_b.pop_front();
      else                got = ~exp;
      check_eq(tag, 32'(got), 32'(exp));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int v0, snap;
      if_a.data_out_ready = 1'b0;
      if_b.data_out_ready = 1'b0;
      step(5);
      check_eq("rst_valid_a", 32'(if_a.data_out_valid), 0);
      check_eq("rst_data_a", 32'(if_a.data_out), 0);
      check_eq("rst_count_a", 32'(cnt_a), 0);
      check_eq("rst_overrun_a", 32'(ovr_a), 0);
      check_eq("rst_busy_a", 32'(busy_a), 0);
      check_eq("rst_valid_b", 32'(if_b.data_out_valid), 0);
      check_eq("rst_busy_b", 32'(busy_b), 0);
      rst = 1'b0;
      step(5);

      // 8N1 0xA5 with ready held high: one valid cycle, clean entry.
      if_a.data_out_ready = 1'b1;
      if_b.data_out_ready = 1'b1;
      v0 = vcyc_a;
      send(0, frame8(8'hA5), 10);
      step(10);
      check_eq("t1_valid_cycles", 32'(vcyc_a - v0), 1);
      expect_a("t1_entry", 10'h0A5);
      check_eq("t1_count", 32'(cnt_a), 0);

      // 7E2 0x35: wrong parity, right parity, then second stop bit low.
      send(1, {5'b0, 1'b1, 1'b1, 1'b1, 7'h35, 1'b0}, 11);
      step(10);
      expect_b("t2_par_bad", 9'h135);
      send(1, {5'b0, 1'b1, 1'b1, 1'b0, 7'h35, 1'b0}, 11);
      step(10);
      expect_b("t2_par_ok", 9'h035);
      send(1, {5'b0, 1'b0, 1'b1, 1'b0, 7'h35, 1'b0}, 11);
      step(10);
      expect_b("t2_stop2_low", 9'h0B5);
      check_eq("t2_busy_b", 32'(busy_b), 0);
      check_eq("t2_qsize_b", 32'(q_b.size()), 0);

      // Short low glitch is rejected as a false start.
      ser_a = 1'b0;
      step(4);
      check_eq("t3_busy_hi", 32'(busy_a), 1);
      ser_a = 1'b1;
      step(16);
      check_eq("t3_busy_lo", 32'(busy_a), 0);
      check_eq("t3_count", 32'(cnt_a), 0);
      check_eq("t3_qsize", 32'(q_a.size()), 0);
      step(BIT);
      send(0, frame8(8'h3C), 10);
      step(10);
      expect_a("t3_entry", 10'h03C);

      // Fill the FIFO, overflow, clear, and overflow again with clear held.
      if_a.data_out_ready = 1'b0;
      for (int d = 1; d <= 5; d++) send(0, frame8(8'(d)), 10);
      step(10);
      check_eq("t4_count_full", 32'(cnt_a), 4);
      check_eq("t4_overrun", 32'(ovr_a), 1);
      check_eq("t4_valid", 32'(if_a.data_out_valid), 1);
      check_eq("t4_head", 32'(if_a.data_out), 1);
      clr_a = 1'b1;
      step(1);
      clr_a = 1'b0;
      step(1);
      check_eq("t4_cleared", 32'(ovr_a), 0);
      snap = ovr_cyc_a;
      clr_a = 1'b1;
      send(0, frame8(8'h06), 10);
      step(10);
      clr_a = 1'b0;
      check_eq("t4_set_wins", 32'(ovr_cyc_a > snap), 1);
      check_eq("t4_cleared2", 32'(ovr_a), 0);
      if_a.data_out_ready = 1'b1;
      step(8);
      if_a.data_out_ready = 1'b0;
      for (int d = 1; d <= 4; d++) expect_a("t4_pop", 10'(d));
      check_eq("t4_qsize", 32'(q_a.size()), 0);
      check_eq("t4_count_empty", 32'(cnt_a), 0);

      // Break: 20 symbols low yields one framing-error entry, then 0x5A.
      if_a.data_out_ready = 1'b1;
      ser_a = 1'b0;
      step(20 * BIT);
      ser_a = 1'b1;
      step(2 * BIT);
      send(0, frame8(8'h5A), 10);
      step(10);
      expect_a("t5_break", 10'h100);
      expect_a("t5_after", 10'h05A);
      check_eq("t5_qsize", 32'(q_a.size()), 0);

      // Reset part-way through a frame leaves no partial entry.
      send(0, 16'b0000_0000_0001_1110, 5);
      check_eq("t6_busy_pre", 32'(busy_a), 1);
      rst = 1'b1;
      step(3);
      check_eq("t6_busy_rst", 32'(busy_a), 0);
      check_eq("t6_count_rst", 32'(cnt_a), 0);
      rst = 1'b0;
      step(2 * BIT);
      send(0, frame8(8'h81), 10);
      step(10);
      expect_a("t6_entry", 10'h081);
      check_eq("t6_qsize", 32'(q_a.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
